// File: rtl/ysyx_24110006_axi_pkg.sv
// ysyx_24110006_axi_pkg: AXI read-slave burst/resp encodings, FSM states, and burst-error/address-map helpers
package ysyx_24110006_axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_WAIT  = 2'd1;
  localparam state_t S_BURST = 2'd2;
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    return size != SIZE_WORD || burst == BURST_RSVD ||
           (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  function automatic logic in_map(input logic [31:0] a, input logic [31:0] base, input logic [32:0] bytes);
    return a >= base && {1'b0, a - base} < bytes;
  endfunction
endpackage

// File: rtl/ysyx_24110006_axi_addr_gen.sv
// ysyx_24110006_axi_addr_gen: next beat address from i_addr/i_len/i_burst (o_next) and map range check of i_chk (o_hit)
module ysyx_24110006_axi_addr_gen
  import ysyx_24110006_axi_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096
) (
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [1:0]  i_burst,
  input  logic [31:0] i_chk,
  output logic [31:0] o_next,
  output logic        o_hit
);
  logic [31:0] inc, mask;
  always_comb begin
    inc    = i_addr + 32'd4;
    mask   = (({24'd0, i_len} + 32'd1) << 2) - 32'd1;
    o_next = i_burst == BURST_INCR ? inc :
             i_burst == BURST_WRAP ? (i_addr & ~mask) | (inc & mask) : i_addr;
    o_hit  = in_map(i_chk, BASE, 33'(DEPTH) << 2);
  end
endmodule

// File: rtl/ysyx_24110006_axi_rd_slave.sv
// ysyx_24110006_axi_rd_slave: AXI4 AR/R responder over a DEPTH-word SRAM (AR in, R out, backdoor i_bd_* preload), LATENCY idle cycles before first beat
module ysyx_24110006_axi_rd_slave
  import ysyx_24110006_axi_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  output logic [1:0]  o_axi_rresp,
  output logic [3:0]  o_axi_rid,
  output logic        o_axi_rlast,
  input  logic        i_bd_wen,
  input  logic [31:0] i_bd_waddr,
  input  logic [31:0] i_bd_wdata
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  state_t      state;
  logic [3:0]  cnt, id_q;
  logic [31:0] addr_q, ld_addr, ld_off, bd_off, nxt;
  logic [7:0]  len_q, beat_q;
  logic [1:0]  burst_q;
  logic        err_q, hs, retire, load0, loadw, loadn, load, ld_err, ld_last, hit;
  assign o_axi_arready = state == S_IDLE;
  assign o_axi_rid     = id_q;
  always_comb begin
    hs      = i_axi_arvalid && o_axi_arready;
    retire  = o_axi_rvalid && i_axi_rready;
    load0   = hs && LATENCY == 0;
    loadw   = state == S_WAIT && cnt == 4'd1;
    loadn   = retire && !o_axi_rlast;
    load    = load0 || loadw || loadn;
    ld_addr = load0 ? i_axi_araddr & ~32'h3 : loadw ? addr_q : nxt;
    ld_err  = load0 ? burst_err(i_axi_arsize, i_axi_arburst, i_axi_arlen) : err_q;
    ld_last = load0 ? i_axi_arlen == 8'd0 : loadw ? len_q == 8'd0 : beat_q + 8'd1 == len_q;
    ld_off  = ld_addr - BASE;
    bd_off  = i_bd_waddr - BASE;
  end
  ysyx_24110006_axi_addr_gen #(.BASE(BASE), .DEPTH(DEPTH)) u_addr_gen (
    .i_addr (addr_q),
    .i_len  (len_q),
    .i_burst(burst_q),
    .i_chk  (ld_addr),
    .o_next (nxt),
    .o_hit  (hit)
  );
  always_ff @(posedge i_clock)
    if (i_bd_wen && in_map(i_bd_waddr, BASE, 33'(DEPTH) << 2)) mem[AW'(bd_off >> 2)] <= i_bd_wdata;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      o_axi_rvalid <= 1'b0;
      o_axi_rlast  <= 1'b0;
      o_axi_rresp  <= RESP_OKAY;
      o_axi_rdata  <= '0;
    end else begin
      if (hs) begin
        addr_q  <= i_axi_araddr & ~32'h3;
        id_q    <= i_axi_arid;
        len_q   <= i_axi_arlen;
        burst_q <= i_axi_arburst;
        err_q   <= burst_err(i_axi_arsize, i_axi_arburst, i_axi_arlen);
        beat_q  <= '0;
        cnt     <= 4'(LATENCY);
        state   <= LATENCY == 0 ? S_BURST : S_WAIT;
      end
      if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= S_BURST;
      end
      if (retire) begin
        beat_q <= beat_q + 8'd1;
        addr_q <= nxt;
        if (o_axi_rlast) begin
          state        <= S_IDLE;
          o_axi_rvalid <= 1'b0;
        end
      end
      if (load) begin
        o_axi_rvalid <= 1'b1;
        o_axi_rlast  <= ld_last;
        o_axi_rresp  <= ld_err ? RESP_SLVERR : hit ? RESP_OKAY : RESP_DECERR;
        o_axi_rdata  <= ld_err || !hit ? 32'd0 : mem[AW'(ld_off >> 2)];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24110006_axi_rd_slave.sv
// tb_ysyx_24110006_axi_rd_slave: scoreboard bench for the AXI read slave with directed bursts
module tb_ysyx_24110006_axi_rd_slave;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr = '0, rdata, bd_waddr = '0, bd_wdata = '0;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b1, rlast, bd_wen = 1'b0;
  logic [3:0]  arid = '0, rid;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01, rresp;
  typedef struct packed {logic [31:0] d; logic [1:0] r; logic [3:0] id; logic l;} beat_t;
  beat_t q[$];
  int n_tests = 0, n_fail = 0, beats_seen = 0;
  logic prev_stall = 1'b0;
  logic [39:0] prev_out = '0;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  always #5 clk = ~clk;
  ysyx_24110006_axi_rd_slave dut (
    .i_clock(clk), .i_reset(rst),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .i_axi_arid(arid), .i_axi_arlen(arlen), .i_axi_arsize(arsize), .i_axi_arburst(arburst),
    .o_axi_rdata(rdata), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_axi_rresp(rresp), .o_axi_rid(rid), .o_axi_rlast(rlast),
    .i_bd_wen(bd_wen), .i_bd_waddr(bd_waddr), .i_bd_wdata(bd_wdata)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    beat_t e;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("hold", {rvalid, rdata, rresp, rid, rlast}, prev_out);
      if (rvalid && rready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {rdata, rresp, rid, rlast});
        end else begin
          e = q.pop_front();
          chk("beat", {rdata, rresp, rid, rlast}, e);
        end
        beats_seen++;
      end
      prev_stall = rvalid && !rready;
      prev_out = {rvalid, rdata, rresp, rid, rlast};
    end
  end
  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic [3:0] id, input logic l);
    q.push_back('{d: d, r: r, id: id, l: l});
  endtask
  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_wen = 1'b1; bd_waddr = a; bd_wdata = d;
    @(posedge clk); #1 bd_wen = 1'b0;
  endtask
  task automatic issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] b);
    @(negedge clk);
    chk("arready_idle", arready, 1);
    araddr = a; arid = id; arlen = len; arsize = sz; arburst = b; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
  endtask
  task automatic wait_beats(input int n);
    for (int i = 0; i < 100 && beats_seen < n; i++) begin @(posedge clk); #1; end
    if (beats_seen < n) chk("wait_beats_timeout", 64'(beats_seen), 64'(n));
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain_left", 64'(q.size()), 0);
    q.delete();
    @(negedge clk);
    chk("arready_after", arready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("rst_outs", {rvalid, rlast, rresp, rid, rdata}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arready", arready, 1);
    for (int i = 0; i < 8; i++) bd_write(32'h8000_0000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    bd_write(32'h8000_0010, 32'h0000_0013);
    bd_write(32'h8000_3FFC, 32'hDEAD_BEEF);
    bd_write(32'h8000_4000, 32'hBAD0_BAD0);
    push(32'h13, OK, 4'h1, 1'b1);
    issue(32'h8000_0010, 4'h1, 8'd0, 3'b010, INCR);
    @(negedge clk); chk("lat_n1_rvalid", rvalid, 0);
    @(negedge clk); chk("lat_n2_rvalid", rvalid, 1);
    drain();
    push(32'hC0DE_0000, OK, 4'h2, 1'b0);
    push(32'hC0DE_0001, OK, 4'h2, 1'b0);
    push(32'hC0DE_0002, OK, 4'h2, 1'b0);
    push(32'hC0DE_0003, OK, 4'h2, 1'b1);
    base = beats_seen;
    issue(32'h8000_0000, 4'h2, 8'd3, 3'b010, INCR);
    wait_beats(base + 1);
    rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rready = 1'b1;
    drain();
    push(32'hC0DE_0002, OK, 4'h3, 1'b0);
    push(32'hC0DE_0003, OK, 4'h3, 1'b0);
    push(32'hC0DE_0000, OK, 4'h3, 1'b0);
    push(32'hC0DE_0001, OK, 4'h3, 1'b1);
    issue(32'h8000_0008, 4'h3, 8'd3, 3'b010, WRAP);
    drain();
    push(32'h0, SLV, 4'h3, 1'b0);
    push(32'h0, SLV, 4'h3, 1'b0);
    push(32'h0, SLV, 4'h3, 1'b1);
    issue(32'h8000_0008, 4'h3, 8'd2, 3'b010, WRAP);
    drain();
    push(32'h0, DEC, 4'h4, 1'b0);
    push(32'h0, DEC, 4'h4, 1'b1);
    issue(32'h0F00_0000, 4'h4, 8'd1, 3'b010, INCR);
    drain();
    push(32'hDEAD_BEEF, OK, 4'h4, 1'b0);
    push(32'h0, DEC, 4'h4, 1'b1);
    issue(32'h8000_3FFC, 4'h4, 8'd1, 3'b010, INCR);
    drain();
    push(32'h0, SLV, 4'h6, 1'b0);
    push(32'h0, SLV, 4'h6, 1'b1);
    issue(32'h8000_0000, 4'h6, 8'd1, 3'b011, INCR);
    drain();
    push(32'h0, SLV, 4'h6, 1'b1);
    issue(32'h8000_0000, 4'h6, 8'd0, 3'b010, 2'b11);
    drain();
    push(32'hC0DE_0001, OK, 4'h5, 1'b0);
    push(32'hC0DE_0001, OK, 4'h5, 1'b0);
    push(32'hC0DE_0001, OK, 4'h5, 1'b1);
    issue(32'h8000_0004, 4'h5, 8'd2, 3'b010, FIXED);
    drain();
    push(32'hC0DE_0000, OK, 4'h7, 1'b0);
    push(32'hC0DE_0001, OK, 4'h7, 1'b0);
    base = beats_seen;
    issue(32'h8000_0000, 4'h7, 8'd7, 3'b010, INCR);
    wait_beats(base + 2);
    rready = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_async_rvalid", rvalid, 0);
    chk("rst_beats_left", 64'(q.size()), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("rst_release_arready", arready, 1);
    chk("rst_release_rvalid", rvalid, 0);
    push(32'h0000_0013, OK, 4'h8, 1'b0);
    push(32'hC0DE_0005, OK, 4'h8, 1'b1);
    issue(32'h8000_0010, 4'h8, 8'd1, 3'b010, INCR);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
